// File: rtl/io_bridge.sv
// Memory-mapped peripheral bridge: LED, switch, debounced button, seven-segment and cycle-counter registers.
// Optional cycle counter at 0xFC40 is built only when IO_CYCLE_CNT_EN is defined.
module io_bridge #(
   parameter int unsigned SW_W       = 16,
   parameter int unsigned LED_W      = 16,
   parameter logic [19:0] DEB_CYCLES = 20'd1_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic              ioRead,
   input  logic              ioWrite,
   output logic [31:0]       rdata,
   input  logic [SW_W-1:0]   sw,
   input  logic [3:0]        btn,
   output logic [LED_W-1:0]  led,
   output logic [31:0]       seg_data
);

   localparam int unsigned CW      = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 20'd1);

   // Word offsets (addr[15:2]) of the mapped registers
   localparam logic [13:0] OFF_LED = 14'h3F00;
   localparam logic [13:0] OFF_SW  = 14'h3F04;
   localparam logic [13:0] OFF_BTN = 14'h3F08;
   localparam logic [13:0] OFF_SEG = 14'h3F0C;
   localparam logic [13:0] OFF_CYC = 14'h3F10;

   logic [13:0]     off;
   logic [SW_W-1:0] sw_s1, sw_s2;
   logic [3:0]      btn_s1, btn_s2;
   logic [3:0]      lvl, flag, rise;
   logic [CW-1:0]   cnt [4];
   logic            btn_clr;

   assign off     = addr[15:2];
   assign btn_clr = ioRead && (off == OFF_BTN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1  <= '0;
         sw_s2  <= '0;
         btn_s1 <= '0;
         btn_s2 <= '0;
      end else begin
         sw_s1  <= sw;
         sw_s2  <= sw_s1;
         btn_s1 <= btn;
         btn_s2 <= btn_s1;
      end
   end

   // A rising debounced level is detected on the same edge the toggle happens
   always_comb begin
      rise = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         rise[i] = ~lvl[i] & btn_s2[i] & (cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl  <= '0;
         flag <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (btn_s2[i] != lvl[i]) begin
               if (cnt[i] == CNT_MAX) begin
                  lvl[i] <= ~lvl[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
         // Set has priority over a read-clear landing on the same edge
         flag <= (flag & ~{4{btn_clr}}) | rise;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led      <= '0;
         seg_data <= '0;
      end else if (ioWrite) begin
         if (off == OFF_LED) led <= wdata[LED_W-1:0];
         if (off == OFF_SEG) seg_data <= wdata;
      end
   end

`ifdef IO_CYCLE_CNT_EN
   logic [31:0] cyc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc <= '0;
      end else if (ioWrite && (off == OFF_CYC)) begin
         cyc <= wdata;
      end else begin
         cyc <= cyc + 32'd1;
      end
   end
`endif

   always_comb begin
      rdata = '0;
      if (ioRead) begin
         case (off)
            OFF_LED: rdata = 32'(led);
            OFF_SW:  rdata = 32'(sw_s2);
            OFF_BTN: rdata = {24'd0, lvl, flag};
            OFF_SEG: rdata = seg_data;
`ifdef IO_CYCLE_CNT_EN
            OFF_CYC: rdata = cyc;
`endif
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_bridge.sv
// Randomized bench for io_bridge against a behavioural register-map model; honours IO_CYCLE_CNT_EN.
module tb_io_bridge;

   localparam int DEB = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr, wdata, rdata, seg_data;
   logic        ioRead, ioWrite;
   logic [15:0] sw, led;
   logic [3:0]  btn;

   io_bridge #(.SW_W(16), .LED_W(16), .DEB_CYCLES(20'd4)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
      .ioRead(ioRead), .ioWrite(ioWrite), .rdata(rdata),
      .sw(sw), .btn(btn), .led(led), .seg_data(seg_data)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [15:0] m_led;
   logic [31:0] m_seg, m_cyc;
   logic [3:0]  m_lvl, m_flag;
   logic [15:0] m_swq[$];
   logic [3:0]  m_btnq[$];
   logic [3:0]  m_hist[$];
   int          m_last_tog[4];
   logic [15:0] cur_sw;
   logic [3:0]  cur_btn;

   function automatic void model_reset();
      m_led = '0; m_seg = '0; m_cyc = '0; m_lvl = '0; m_flag = '0;
      m_swq = {16'h0, 16'h0};
      m_btnq = {4'h0, 4'h0};
      m_hist = {};
      for (int i = 0; i < 4; i++) m_last_tog[i] = 0;
   endfunction

   function automatic logic [31:0] m_read(input logic r, input logic [31:0] a);
      logic [15:0] o;
      o = {a[15:2], 2'b00};
      if (!r) return 32'h0;
      case (o)
         16'hFC00: return {16'h0, m_led};
         16'hFC10: return {16'h0, m_swq[0]};
         16'hFC20: return {24'h0, m_lvl, m_flag};
         16'hFC30: return m_seg;
`ifdef IO_CYCLE_CNT_EN
         16'hFC40: return m_cyc;
`endif
         default:  return 32'h0;
      endcase
   endfunction

   // One clock edge: a button level flips once its synced sample has disagreed for DEB consecutive edges
   function automatic void model_edge(input logic r, input logic w, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [15:0] s, input logic [3:0] b);
      logic [15:0] o;
      logic [3:0]  set, h;
      int          n;
      bit          ok;
      o = {a[15:2], 2'b00};
      set = '0;
      m_hist.push_back(m_btnq[0]);
      n = m_hist.size();
      for (int i = 0; i < 4; i++) begin
         if (n - m_last_tog[i] >= DEB) begin
            ok = 1'b1;
            for (int k = n - DEB; k < n; k++) begin
               h = m_hist[k];
               if (h[i] == m_lvl[i]) ok = 1'b0;
            end
            if (ok) begin
               m_lvl[i] = ~m_lvl[i];
               m_last_tog[i] = n;
               if (m_lvl[i]) set[i] = 1'b1;
            end
         end
      end
      if (r && o == 16'hFC20) m_flag = '0;
      m_flag = m_flag | set;
      if (w && o == 16'hFC00) m_led = wd[15:0];
      if (w && o == 16'hFC30) m_seg = wd;
      if (w && o == 16'hFC40) m_cyc = wd;
      else                    m_cyc = m_cyc + 32'd1;
      m_swq.push_back(s);
      void'(m_swq.pop_front());
      m_btnq.push_back(b);
      void'(m_btnq.pop_front());
   endfunction

   task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd_o);
      @(negedge clk);
      ioRead = r; ioWrite = w; addr = a; wdata = wd; sw = cur_sw; btn = cur_btn;
      #1;
      check("rdata", rdata, m_read(r, a));
      check("led", {16'h0, led}, {16'h0, m_led});
      check("seg", seg_data, m_seg);
      rd_o = rdata;
      @(posedge clk);
      model_edge(r, w, a, wd, cur_sw, cur_btn);
   endtask

   logic [31:0] rd;
   logic [31:0] ra;
   logic [15:0] offs [6];

   initial begin
      offs = '{16'hFC00, 16'hFC10, 16'hFC20, 16'hFC30, 16'hFC40, 16'hFC50};
      rst_n = 1'b0; ioRead = 1'b0; ioWrite = 1'b0; addr = '0; wdata = '0;
      sw = '0; btn = '0; cur_sw = '0; cur_btn = '0;
      model_reset();
      #1;
      check("reset_rdata", rdata, 32'h0);
      check("reset_led", {16'h0, led}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // LED store and readback, unmapped read
      step(1'b0, 1'b1, 32'hFFFF_FC00, 32'hDEAD_BEEF, rd);
      step(1'b1, 1'b0, 32'hFFFF_FC00, 32'h0, rd);
      check("led_beef", {16'h0, led}, 32'h0000_BEEF);
      check("rd_led", rd, 32'h0000_BEEF);
      step(1'b1, 1'b0, 32'hFFFF_FC50, 32'h0, rd);
      check("rd_unmapped", rd, 32'h0);

      // Switch synchroniser latency
      cur_sw = 16'hA5A5;
      step(1'b1, 1'b0, 32'hFFFF_FC10, 32'h0, rd);
      check("sw_edge0", rd, 32'h0);
      step(1'b1, 1'b0, 32'hFFFF_FC10, 32'h0, rd);
      check("sw_edge1", rd, 32'h0);
      step(1'b1, 1'b0, 32'hFFFF_FC10, 32'h0, rd);
      check("sw_edge2", rd, 32'h0000_A5A5);

      // Short glitch on btn[2]
      cur_btn = 4'h4;
      repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0, rd);
      cur_btn = 4'h0;
      repeat (8) step(1'b0, 1'b0, 32'h0, 32'h0, rd);
      step(1'b1, 1'b0, 32'hFFFF_FC20, 32'h0, rd);
      check("btn_glitch", rd, 32'h0);

      // Long press, sticky flag then read-clear
      cur_btn = 4'h4;
      repeat (10) step(1'b0, 1'b0, 32'h0, 32'h0, rd);
      step(1'b1, 1'b0, 32'hFFFF_FC20, 32'h0, rd);
      check("btn_press", rd, 32'h44);
      step(1'b1, 1'b0, 32'hFFFF_FC20, 32'h0, rd);
      check("btn_cleared", rd, 32'h40);

      // Release, then press again while reading every cycle (covers read on the setting edge)
      cur_btn = 4'h0;
      repeat (10) step(1'b0, 1'b0, 32'h0, 32'h0, rd);
      cur_btn = 4'h4;
      repeat (10) step(1'b1, 1'b0, 32'hFFFF_FC20, 32'h0, rd);
      check("btn_reread", rd, 32'h40);

      // Cycle counter wrap
      step(1'b0, 1'b1, 32'hFFFF_FC40, 32'hFFFF_FFFE, rd);
      step(1'b1, 1'b0, 32'hFFFF_FC40, 32'h0, rd);
      step(1'b1, 1'b0, 32'hFFFF_FC40, 32'h0, rd);
`ifdef IO_CYCLE_CNT_EN
      check("cyc_ffff", rd, 32'hFFFF_FFFF);
`else
      check("cyc_absent", rd, 32'h0);
`endif
      step(1'b1, 1'b0, 32'hFFFF_FC40, 32'h0, rd);
      check("cyc_wrap", rd, 32'h0);

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 5) == 0) cur_btn = 4'($urandom);
         if ($urandom_range(0, 9) == 0) cur_sw = 16'($urandom);
         ra = {16'hFFFF, offs[$urandom_range(0, 5)][15:2], 2'($urandom)};
         if ($urandom_range(0, 9) == 0) ra[15:0] = 16'($urandom);
         step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, ra, $urandom, rd);
      end

      // Asynchronous reset mid-cycle
      cur_btn = 4'h0;
      step(1'b0, 1'b1, 32'hFFFF_FC00, 32'h0000_00FF, rd);
      step(1'b0, 1'b1, 32'hFFFF_FC30, 32'h1234_5678, rd);
      @(negedge clk);
      ioRead = 1'b1; ioWrite = 1'b0; addr = 32'hFFFF_FC00;
      #1;
      check("pre_rst_led", {16'h0, led}, 32'h0000_00FF);
      #2 rst_n = 1'b0;
      #1;
      check("rst_led", {16'h0, led}, 32'h0);
      check("rst_seg", seg_data, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      addr = 32'hFFFF_FC20;
      #1;
      check("rst_flags", rdata, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 32'hFFFF_FC00, 32'h0, rd);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
